rainbow_gradient_engine: RTL



---
 rtl/rainbow_pkg.sv | 54 +++++
 rtl/rainbow_offset_ctrl.sv | 87 ++++++++
 rtl/rainbow_gradient_engine.sv | 87 ++++++++
 3 files changed

// File: rtl/rainbow_pkg.sv
// Shared encodings and the default 32-entry colour gradient for the rainbow engine.
package rainbow_pkg;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_FWD    = 2'd1;
    localparam logic [1:0] MODE_REV    = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Red-to-blue sweep in 4:4:4 RGB; larger tables wrap onto these 32 entries.
    function automatic logic [11:0] gradient_entry(input int unsigned i);
        logic [11:0] c;
        case (i % 32)
            0:       c = 12'hF00;
            1:       c = 12'hE10;
            2:       c = 12'hE30;
            3:       c = 12'hD41;
            4:       c = 12'hD51;
            5:       c = 12'hC72;
            6:       c = 12'hC82;
            7:       c = 12'hB93;
            8:       c = 12'hBA3;
            9:       c = 12'hAB4;
            10:      c = 12'hAC4;
            11:      c = 12'h9D5;
            12:      c = 12'h9E5;
            13:      c = 12'h8E6;
            14:      c = 12'h8E6;
            15:      c = 12'h7E7;
            16:      c = 12'h7E7;
            17:      c = 12'h6E8;
            18:      c = 12'h6E8;
            19:      c = 12'h5E9;
            20:      c = 12'h5D9;
            21:      c = 12'h4CA;
            22:      c = 12'h4BA;
            23:      c = 12'h3AB;
            24:      c = 12'h39B;
            25:      c = 12'h28C;
            26:      c = 12'h27C;
            27:      c = 12'h15D;
            28:      c = 12'h14D;
            29:      c = 12'h03E;
            30:      c = 12'h01E;
            default: c = 12'h00F;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rainbow_offset_ctrl.sv
// Per-frame animation offset: static, scroll forward/reverse, or bounce between the table ends.
module rainbow_offset_ctrl
    import rainbow_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned SPEED_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_frame_tick,
    input  logic [1:0]               i_mode,
    input  logic [SPEED_W-1:0]       i_speed,
    output logic [$clog2(DEPTH)-1:0] o_offset
);

    localparam int unsigned OFF_W = $clog2(DEPTH);
    // Wide enough for offset+eff (< 2*DEPTH) and for an unclamped speed value.
    localparam int unsigned SUM_W = ((OFF_W > SPEED_W) ? OFF_W : SPEED_W) + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
    localparam logic [SUM_W-1:0] LAST_S  = SUM_W'(DEPTH - 1);

    logic [OFF_W-1:0] r_offset;
    logic [OFF_W-1:0] w_offset_next;
    dir_e             r_dir;
    dir_e             w_dir_next;
    logic [SUM_W-1:0] w_spd;
    logic [SUM_W-1:0] w_eff;
    logic [SUM_W-1:0] w_off;
    logic [SUM_W-1:0] w_sum;

    assign w_spd = SUM_W'(i_speed);
    assign w_off = SUM_W'(r_offset);
    assign w_eff = (w_spd > LAST_S) ? LAST_S : w_spd;
    assign w_sum = w_off + w_eff;

    always_comb begin
        w_offset_next = r_offset;
        w_dir_next    = r_dir;
        if (i_frame_tick) begin
            case (i_mode)
                MODE_STATIC: begin
                    w_offset_next = '0;
                    w_dir_next    = DIR_UP;
                end
                MODE_FWD: begin
                    w_offset_next = (w_sum >= DEPTH_S) ? OFF_W'(w_sum - DEPTH_S) : OFF_W'(w_sum);
                end
                MODE_REV: begin
                    w_offset_next = (w_off >= w_eff) ? OFF_W'(w_off - w_eff)
                                                     : OFF_W'(w_off + DEPTH_S - w_eff);
                end
                MODE_BOUNCE: begin
                    if (r_dir == DIR_UP) begin
                        if (w_sum >= LAST_S) begin
                            w_offset_next = OFF_W'(LAST_S);
                            w_dir_next    = DIR_DOWN;
                        end else begin
                            w_offset_next = OFF_W'(w_sum);
                        end
                    end else begin
                        if (w_off <= w_eff) begin
                            w_offset_next = '0;
                            w_dir_next    = DIR_UP;
                        end else begin
                            w_offset_next = OFF_W'(w_off - w_eff);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_offset <= '0;
            r_dir    <= DIR_UP;
        end else begin
            r_offset <= w_offset_next;
            r_dir    <= w_dir_next;
        end
    end

    assign o_offset = r_offset;

endmodule

// File: rtl/rainbow_gradient_engine.sv
// Animated gradient lookup: pixel address -> RGB colour through a 2-stage valid-tagged pipeline.
module rainbow_gradient_engine
    import rainbow_pkg::*;
#(
    parameter int unsigned        ADDR_W        = 7,
    parameter int unsigned        COLOR_W       = 12,
    parameter int unsigned        BASE          = 24,
    parameter int unsigned        DEPTH         = 32,
    parameter int unsigned        SPEED_W       = 4,
    parameter logic [COLOR_W-1:0] DEFAULT_COLOR = 12'h00F
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     in_valid,
    input  logic                     frame_tick,
    input  logic [1:0]               mode,
    input  logic [SPEED_W-1:0]       speed,
    output logic [COLOR_W-1:0]       color,
    output logic                     out_valid,
    output logic [$clog2(DEPTH)-1:0] offset
);

    localparam int unsigned OFF_W = $clog2(DEPTH);
    localparam int unsigned IDX_W = ADDR_W + 1;

    logic [OFF_W-1:0]   w_offset;
    logic               w_in_window;
    logic [IDX_W-1:0]   w_rel;
    logic [IDX_W-1:0]   w_sum;
    logic [OFF_W-1:0]   w_idx;

    logic               r_s1_valid;
    logic               r_s1_win;
    logic [OFF_W-1:0]   r_s1_idx;
    logic [COLOR_W-1:0] r_color;
    logic               r_out_valid;

    rainbow_offset_ctrl #(
        .DEPTH   (DEPTH),
        .SPEED_W (SPEED_W)
    ) u_offset_ctrl (
        .clk          (clk),
        .reset        (reset),
        .i_frame_tick (frame_tick),
        .i_mode       (mode),
        .i_speed      (speed),
        .o_offset     (w_offset)
    );

    assign w_in_window = (32'(addr) >= BASE) && (32'(addr) < BASE + DEPTH);

    // Both terms are below DEPTH inside the window, so one conditional subtract wraps the sum.
    assign w_rel = IDX_W'(addr) - IDX_W'(BASE);
    assign w_sum = w_rel + IDX_W'(w_offset);
    assign w_idx = (w_sum >= IDX_W'(DEPTH)) ? OFF_W'(w_sum - IDX_W'(DEPTH)) : OFF_W'(w_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_win   <= 1'b0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_win   <= w_in_window;
            r_s1_idx   <= w_idx;
        end
    end

    // Registered ROM read; colour holds across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_color     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_color <= r_s1_win ? COLOR_W'(gradient_entry(32'(r_s1_idx))) : DEFAULT_COLOR;
            end
        end
    end

    assign color     = r_color;
    assign out_valid = r_out_valid;
    assign offset    = w_offset;

endmodule
